run_length_detector: RTL

- Parametrised successor to the fixed four-zeros/four-ones sequence detector FSM.
- Detects a run of RUN_LEN consecutive identical bits on a serial input that has a valid qualifier.
- Mode selects which polarity may match. Output flag is registered and reports the matched polarity.
- Keeps a saturating count of completed runs. Sits after the serial input synchroniser; feeds the lab display / status logic.

---
 rtl/run_length_detector_pkg.sv | 31 +++
 rtl/run_length_detector_if.sv | 23 ++
 rtl/run_length_detector_sat_counter.sv | 27 ++
 rtl/run_length_detector.sv | 101 ++++++++++
 4 files changed

// File: rtl/run_length_detector_pkg.sv
// Shared types and helpers for the run-length detector.
// Holds state encoding, mode constants and the polarity filter.
package run_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN0 = 2'b01,
        RUN1 = 2'b10
    } state_t;

    localparam logic [1:0] MODE_BOTH  = 2'b00;
    localparam logic [1:0] MODE_ZEROS = 2'b01;
    localparam logic [1:0] MODE_ONES  = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

    function automatic logic mode_permits(
        input logic [1:0] mode,
        input logic       b
    );
        logic ok;
        ok = 1'b0;
        unique case (mode)
            MODE_BOTH:  ok = 1'b1;
            MODE_ZEROS: ok = ~b;
            MODE_ONES:  ok = b;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// Serial-in / status-out bundle of the run-length detector.
// master drives the sample stream, slave is the detector.
interface run_length_detector_if #(
    parameter int CNT_W = 8
);
    logic             clear;
    logic             w_valid;
    logic             w;
    logic [1:0]       mode;
    logic             z;
    logic             z_val;
    logic [CNT_W-1:0] match_count;

    modport master (
        output clear, w_valid, w, mode,
        input  z, z_val, match_count
    );

    modport slave (
        input  clear, w_valid, w, mode,
        output z, z_val, match_count
    );
endinterface

// File: rtl/run_length_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         resetnot,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/run_length_detector.sv
// Flags RUN_LEN consecutive identical valid bits, filtered by mode,
// and counts completed runs in a saturating counter.
module run_length_detector
    import run_detect_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                  clock,
    input  logic                  resetnot,
    run_length_detector_if.slave  bus
);

    localparam int CW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] MAX = CW'(RUN_LEN);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_ext;
    logic            r_z;
    logic            r_z_val;
    logic            w_z_nxt;
    logic            w_z_val_nxt;
    logic            w_inc;
    logic [CNT_W-1:0] w_count;

    assign w_cnt_ext = (r_cnt == MAX) ? MAX : r_cnt + ONE;

    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_z     <= 1'b0;
            r_z_val <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_z     <= w_z_nxt;
            r_z_val <= w_z_val_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_z_nxt     = 1'b0;
        w_z_val_nxt = r_z_val;
        w_inc       = 1'b0;
        if (bus.clear) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_z_val_nxt = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (bus.w_valid) begin
                    w_state_nxt = bus.w ? RUN1 : RUN0;
                    w_cnt_nxt   = ONE;
                end
                RUN0: if (bus.w_valid) begin
                    w_state_nxt = bus.w ? RUN1 : RUN0;
                    w_cnt_nxt   = bus.w ? ONE : w_cnt_ext;
                end
                RUN1: if (bus.w_valid) begin
                    w_state_nxt = bus.w ? RUN1 : RUN0;
                    w_cnt_nxt   = bus.w ? w_cnt_ext : ONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
            // A flag counts as new when it follows a gap or flips polarity.
            if (bus.w_valid && (w_state_nxt != IDLE)) begin
                w_z_nxt = (w_cnt_nxt == MAX)
                        && mode_permits(bus.mode, bus.w);
                if (w_z_nxt) begin
                    w_z_val_nxt = bus.w;
                    w_inc       = !r_z || (r_z_val != bus.w);
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clock    (clock),
        .resetnot (resetnot),
        .i_clear  (bus.clear),
        .i_inc    (w_inc),
        .o_count  (w_count)
    );

    assign bus.z           = r_z;
    assign bus.z_val       = r_z_val;
    assign bus.match_count = w_count;

endmodule
